// File: rtl/lsu_pkg.sv
// Shared encodings, state type and alignment helper for the load/store unit.
package lsu_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned HALF_BITS = 16;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    MERGE,
    WRITE,
    DONE
  } state_e;

  // Half on an odd byte, or word off a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_format
  import lsu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] word,
  input  logic [1:0]       addr_lo,
  input  size_e            size,
  input  logic             is_signed,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] load_val,
  output logic [Width-1:0] store_word
);

  logic [4:0]       shamt;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [Width-1:0] mask;
  logic [Width-1:0] data;

  always_comb begin
    shamt    = {addr_lo, 3'b000};
    lane_b   = 8'(word >> shamt);
    lane_h   = 16'(word >> shamt);
    load_val = word;
    mask     = '1;
    data     = wdata;
    case (size)
      SZ_BYTE: begin
        load_val = {{(Width-BYTE_BITS){is_signed & lane_b[7]}}, lane_b};
        mask     = Width'(8'hFF) << shamt;
        data     = Width'(wdata[7:0]) << shamt;
      end
      SZ_HALF: begin
        load_val = {{(Width-HALF_BITS){is_signed & lane_h[15]}}, lane_h};
        mask     = Width'(16'hFFFF) << shamt;
        data     = Width'(wdata[15:0]) << shamt;
      end
      default: begin
        load_val = word;
      end
    endcase
    // Only the target lane is taken from the store data.
    store_word = (word & ~mask) | (data & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory with 1-cycle read data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned AddrBits = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             resp_valid,
  output logic [Width-1:0] resp_rdata,
  output logic             resp_err,
  output logic [Width-1:0] mem_address,
  output logic [Width-1:0] mem_write_data,
  output logic             mem_memwrite,
  output logic             mem_memread,
  input  logic [Width-1:0] mem_read_data
);

  state_e           state_q, state_d;
  logic             write_q, signed_q;
  size_e            size_q;
  logic [1:0]       addr_lo_q;
  logic [Width-1:0] wdata_q;
  logic [Width-1:0] load_val, merged;
  logic [Width-1:0] resp_rdata_d;
  logic             resp_err_d;
  logic             req_err_c;
  logic             unused_addr_hi;

  // Upper address bits alias onto the 256-word memory.
  assign unused_addr_hi = ^req_addr[Width-1:AddrBits+2];
  assign req_err_c      = (req_size == SZ_ILLEGAL) || is_misaligned(req_size, req_addr[1:0]);

  lsu_lane_format #(.Width(Width)) u_lane (
    .word       (mem_read_data),
    .addr_lo    (addr_lo_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err_c)                             state_d = DONE;
          else if (req_write && req_size == SZ_WORD) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ:                   state_d = write_q ? MERGE : CAPTURE;
      CAPTURE, MERGE, WRITE:  state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    // Response fields change only on entry to DONE, then hold.
    if (state_d == DONE) begin
      resp_err_d   = (state_q == IDLE);
      resp_rdata_d = (state_q == CAPTURE) ? load_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      mem_address <= '0;
    end else if (state_q == IDLE && req_valid) begin
      write_q     <= req_write;
      signed_q    <= req_signed;
      size_q      <= size_e'(req_size);
      addr_lo_q   <= req_addr[1:0];
      wdata_q     <= req_wdata;
      mem_address <= Width'(req_addr[AddrBits+1:2]);
    end
  end

  // Strobes and handshake flags are the registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
    end else begin
      req_ready    <= (state_d == IDLE);
      resp_valid   <= (state_d == DONE);
      resp_rdata   <= resp_rdata_d;
      resp_err     <= resp_err_d;
      mem_memread  <= (state_d == READ);
      mem_memwrite <= (state_d == MERGE) || (state_d == WRITE);
    end
  end

  // Merge data depends on read data arriving during MERGE, so this path is combinational.
  always_comb begin
    mem_write_data = '0;
    if (state_q == MERGE)      mem_write_data = merged;
    else if (state_q == WRITE) mem_write_data = wdata_q;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage that sits directly upstream of the word-addressed data memory. It takes byte-addressed load/store requests from the processor datapath and converts them into word-index accesses. Sub-word stores are done as read-modify-write. Load results are aligned and sign/zero-extended. It drives the memory's address, write_data, memwrite and memread, and consumes its registered read_data, which has 1-cycle latency.

Parameters:
Width, 32, data width of the request path and the memory word
AddrBits, 8, word-index bits forwarded to memory (256 words)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  Width  byte address
req_wdata  in  Width  store data, right-justified
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  Width  load result; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned or illegal size, no memory access made
mem_address  out  Width  word index = zero-extended req_addr[AddrBits+1:2]
mem_write_data  out  Width  word to write
mem_memwrite  out  1  memory write strobe
mem_memread  out  1  memory read strobe
mem_read_data  in  Width  memory registered read data

Behaviour:
- Single clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_memread 0, mem_memwrite 0, mem_address 0, mem_write_data 0.
- Handshake: a request is accepted on a rising edge with req_valid and req_ready both high. All request fields are latched at that edge. The requester may change inputs afterwards. There is no back-pressure on responses.
- Address bits above AddrBits+1 are ignored (aliasing).
- Little-endian lanes:
  - byte k = addr[1:0] occupies bits 8k+7:8k
  - half h = addr[1] occupies bits 16h+15:16h
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Misaligned requests and req_size=11 go IDLE->DONE with resp_err=1. No strobes are raised for them.
- States: IDLE, READ, CAPTURE, MERGE, WRITE, DONE. Strobes are Moore outputs decoded from state only. mem_memread and mem_memwrite are never high together.
- Load sequence:
  - READ: mem_memread=1
  - CAPTURE: extract the lane from mem_read_data, extend it, register it into resp_rdata
  - DONE
  - resp_valid is high in the 3rd cycle after acceptance.
- Word store sequence:
  - WRITE: mem_memwrite=1, mem_write_data=latched wdata
  - DONE
  - resp_valid is high in the 2nd cycle.
- Sub-word store sequence:
  - READ: mem_memread=1
  - MERGE: mem_memwrite=1, mem_write_data = mem_read_data with the target lane replaced by the low byte/half of latched wdata
  - DONE
  - resp_valid is high in the 3rd cycle.
  - mem_memread is 0 during MERGE, so mem_read_data is stable throughout MERGE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- resp_rdata and resp_err hold until the next DONE. resp_rdata is cleared to 0 on a store or error completion.
- Extension: byte/half zero-fill when req_signed=0, replicate the MSB when req_signed=1. Word loads ignore req_signed.
- Reset mid-operation: all strobes drop immediately, because state is forced asynchronously to IDLE. There is no partial response.
  - If reset is asserted during MERGE/WRITE before the edge, no write occurs.
  - The word is never partially modified.
- req_valid while not ready: ignored, not queued.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL
  - state enum
  - function for the misalignment check
- One combinational sub-module, lsu_lane_format:
  - inputs: word, addr[1:0], size, signed, store data
  - outputs: extended load value and merged store word
  - instantiated once
  - FSM and registers stay in load_store_unit.

Test Plan:
- Memory model preloaded mem[i]=i. Load word at 0x0C, accepted cycle 0 -> single memread pulse in cycle 1, mem_address=3, resp_valid only in cycle 3, resp_rdata=0x00000003, resp_err=0.
- Store word 0xDEADBEEF at 0x14 -> one memwrite cycle with mem_address=5, resp_valid in cycle 2; then signed byte load at 0x14 -> 0xFFFFFFEF; unsigned half load at 0x16 -> 0x0000DEAD.
- Store byte 0x7A (req_wdata=0x1234567A) at 0x15 onto word 5=0xDEADBEEF -> READ then MERGE writes 0xDEAD7AEF; word load at 0x14 returns 0xDEAD7AEF.
- Half load at 0x13, word store at 0x16, and req_size=11 -> each gives resp_err=1, resp_rdata=0, resp_valid in cycle 1, no memread/memwrite at any point, memory unchanged.
- Sub-word store at 0x08 (word 2), rst_n pulled low during MERGE before the edge -> mem_memwrite drops immediately, word 2 still 0x00000002, no resp_valid, req_ready=1 after reset release.
- Back-to-back: req_valid held high with two loads -> second accepted only on the edge where the unit is back in IDLE after DONE; req_ready low in READ/CAPTURE/DONE.
